// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vga_pkg
//  Purpose  : 640x480@60 timing constants, RGB332 colour-bar palette and the
//             helpers shared by the VGA timing path.
//  Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

    // 640x480@60 horizontal timing, in pixels
    localparam int unsigned c_H_ACTIVE = 640;
    localparam int unsigned c_H_FP     = 16;
    localparam int unsigned c_H_SYNC   = 96;
    localparam int unsigned c_H_BP     = 48;

    // 640x480@60 vertical timing, in lines
    localparam int unsigned c_V_ACTIVE = 480;
    localparam int unsigned c_V_FP     = 10;
    localparam int unsigned c_V_SYNC   = 2;
    localparam int unsigned c_V_BP     = 33;

    // RGB332 colour bars, left to right
    localparam logic [7:0] c_BAR_WHITE   = 8'hFF;
    localparam logic [7:0] c_BAR_YELLOW  = 8'hFC;
    localparam logic [7:0] c_BAR_CYAN    = 8'h1F;
    localparam logic [7:0] c_BAR_GREEN   = 8'h1C;
    localparam logic [7:0] c_BAR_MAGENTA = 8'hE3;
    localparam logic [7:0] c_BAR_RED     = 8'hE0;
    localparam logic [7:0] c_BAR_BLUE    = 8'h03;
    localparam logic [7:0] c_BAR_BLACK   = 8'h00;

    // Full period of one axis: visible + front porch + sync + back porch
    function automatic int unsigned timing_total(
        input int unsigned active,
        input int unsigned fp,
        input int unsigned sync,
        input int unsigned bp
    );
        return active + fp + sync + bp;
    endfunction

    // Palette lookup for the 3-bit bar index
    function automatic logic [7:0] bar_colour(input logic [2:0] idx);
        logic [7:0] colour;
        case (idx)
            3'd0:    colour = c_BAR_WHITE;
            3'd1:    colour = c_BAR_YELLOW;
            3'd2:    colour = c_BAR_CYAN;
            3'd3:    colour = c_BAR_GREEN;
            3'd4:    colour = c_BAR_MAGENTA;
            3'd5:    colour = c_BAR_RED;
            3'd6:    colour = c_BAR_BLUE;
            default: colour = c_BAR_BLACK;
        endcase
        return colour;
    endfunction

endpackage : vga_pkg
`default_nettype wire

// File: rtl/pix_ce_div.sv
`default_nettype none
// ============================================================================
//  Module   : pix_ce_div
//  Purpose  : Clock-enable divider; pix_ce is high for one clk out of every
//             DIV clks. With DIV = 1 the enable is permanently high.
//  Revision : 1.0 - initial release
// ============================================================================
module pix_ce_div
    import vga_pkg::*;
#(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic pix_ce
);

    // A one-bit counter is kept for DIV = 1; it never leaves zero.
    localparam int unsigned      c_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_W-1:0]   c_LAST = c_W'(DIV - 1);

    logic [c_W-1:0] r_div_cnt;

    // Free-running 0..DIV-1 counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
        end else if (r_div_cnt == c_LAST) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    assign pix_ce = (r_div_cnt == c_LAST);

endmodule : pix_ce_div
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen
//  Purpose  : Parametrised VGA timing generator and pixel output stage.
//             Produces pixel enable, h/v counters, renderer coordinates,
//             polarity-configurable syncs and blanked, registered RGB332
//             with an optional internal 8-bar test pattern.
//  Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned H_ACTIVE = c_H_ACTIVE,
    parameter int unsigned H_FP     = c_H_FP,
    parameter int unsigned H_SYNC   = c_H_SYNC,
    parameter int unsigned H_BP     = c_H_BP,
    parameter int unsigned V_ACTIVE = c_V_ACTIVE,
    parameter int unsigned V_FP     = c_V_FP,
    parameter int unsigned V_SYNC   = c_V_SYNC,
    parameter int unsigned V_BP     = c_V_BP,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned CW       = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pattern_en,
    input  logic [7:0]    pix_in,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          active,
    output logic          pix_ce,
    output logic          line_start,
    output logic          frame_start,
    output logic [2:0]    vgaRed,
    output logic [2:0]    vgaGreen,
    output logic [1:0]    vgaBlue,
    output logic          Hsync,
    output logic          Vsync
);

    localparam int unsigned c_H_TOTAL  = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned c_V_TOTAL  = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned c_BAR_W    = H_ACTIVE / 8;
    localparam int unsigned c_HS_START = H_ACTIVE + H_FP;
    localparam int unsigned c_HS_END   = c_HS_START + H_SYNC;
    localparam int unsigned c_VS_START = V_ACTIVE + V_FP;
    localparam int unsigned c_VS_END   = c_VS_START + V_SYNC;

    logic          w_pix_ce;
    logic [CW-1:0] r_h_cnt;
    logic [CW-1:0] r_v_cnt;
    logic          w_h_last;
    logic          w_v_last;
    logic          w_active;
    logic          w_hs_raw;
    logic          w_vs_raw;
    logic [CW-1:0] r_bar_sub;
    logic [2:0]    r_bar_idx;
    logic          w_bar_last;
    logic [7:0]    w_colour;
    logic [7:0]    r_rgb;
    logic          r_hs;
    logic          r_vs;

    pix_ce_div #(
        .DIV    (CLK_DIV)
    ) u_pix_ce_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .pix_ce (w_pix_ce)
    );

    // Comparisons are done at 32 bits so end-of-window values equal to
    // 2^CW (zero back porch) cannot alias onto small counts.
    assign w_h_last   = (32'(r_h_cnt) == c_H_TOTAL - 1);
    assign w_v_last   = (32'(r_v_cnt) == c_V_TOTAL - 1);
    assign w_active   = (32'(r_h_cnt) < H_ACTIVE) && (32'(r_v_cnt) < V_ACTIVE);
    assign w_hs_raw   = (32'(r_h_cnt) >= c_HS_START) && (32'(r_h_cnt) < c_HS_END);
    assign w_vs_raw   = (32'(r_v_cnt) >= c_VS_START) && (32'(r_v_cnt) < c_VS_END);
    assign w_bar_last = (32'(r_bar_sub) == c_BAR_W - 1);

    // Horizontal and vertical position counters, stepped once per pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_pix_ce) begin
            if (w_h_last) begin
                r_h_cnt <= '0;
                if (w_v_last) begin
                    r_v_cnt <= '0;
                end else begin
                    r_v_cnt <= r_v_cnt + 1'b1;
                end
            end else begin
                r_h_cnt <= r_h_cnt + 1'b1;
            end
        end
    end

    // Bar index tracks h_cnt in BAR_W-pixel steps; zero whenever h_cnt is zero.
    // It keeps counting through blanking, where the colour is masked anyway.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bar_sub <= '0;
            r_bar_idx <= '0;
        end else if (w_pix_ce) begin
            if (w_h_last) begin
                r_bar_sub <= '0;
                r_bar_idx <= '0;
            end else if (w_bar_last) begin
                r_bar_sub <= '0;
                r_bar_idx <= r_bar_idx + 1'b1;
            end else begin
                r_bar_sub <= r_bar_sub + 1'b1;
            end
        end
    end

    assign w_colour = pattern_en ? bar_colour(r_bar_idx) : pix_in;

    // Output register: syncs and colour share one stage so they stay aligned
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rgb <= 8'h00;
            r_hs  <= ~HS_POL;
            r_vs  <= ~VS_POL;
        end else if (w_pix_ce) begin
            r_rgb <= w_active ? w_colour : 8'h00;
            r_hs  <= w_hs_raw ? HS_POL : ~HS_POL;
            r_vs  <= w_vs_raw ? VS_POL : ~VS_POL;
        end
    end

    assign x           = r_h_cnt;
    assign y           = r_v_cnt;
    assign active      = w_active;
    assign pix_ce      = w_pix_ce;
    assign line_start  = w_pix_ce && (r_h_cnt == '0);
    assign frame_start = w_pix_ce && (r_h_cnt == '0) && (r_v_cnt == '0);
    assign vgaRed      = r_rgb[7:5];
    assign vgaGreen    = r_rgb[4:2];
    assign vgaBlue     = r_rgb[1:0];
    assign Hsync       = r_hs;
    assign Vsync       = r_vs;

endmodule : vga_timing_gen
`default_nettype wire
